dvfs_sequencer: RTL and testbench
=================================

# dvfs_sequencer

Sequences operating-point changes for the dynamic power management unit. The policy FSM issues a target (voltage level, frequency level); this block applies it to the rails and clock generator in a safe order. When voltage rises it steps voltage first, one level at a time, then changes frequency. When voltage falls it changes frequency first, then steps voltage down. Each step is held for a settle time. It sits between the DPMU policy FSM and the vcore/fcore output pins.

## Interface
Parameters:
- `V_SETTLE`, default 8: cycles each voltage step is held; must be ≥1.
- `F_SETTLE`, default 4: cycles a frequency change is held; must be ≥1.
- `V_RST`, default 2'b01: reset voltage level (NORMAL point).
- `F_RST`, default 3'b010: reset frequency level (NORMAL point).

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: a new target is offered.
- `req_ready` out 1: block accepts a target this cycle.
- `req_vlevel` in 2: target voltage level.
- `req_flevel` in 3: target frequency level.
- `emerg` in 1: level input; requests the minimum operating point (0, 0).
- `vout` out 2: applied voltage level.
- `fout` out 3: applied frequency level.
- `busy` out 1: a sequence is in progress.
- `done` out 1: one-cycle pulse when a sequence completes.

## Operation
- States: IDLE, V_UP, F_SET, V_DN, DONE.
- Reset values: `vout`=V_RST, `fout`=F_RST, state IDLE, `req_ready`=1, `busy`=0, `done`=0.
- IDLE:
  - `req_ready` = !emerg.
  - If `emerg`=1: latch target (0, 0). `req_valid` is ignored and not accepted.
  - Else if `req_valid`=1: latch (`req_vlevel`, `req_flevel`).
  - Acceptance edge E0 moves the FSM to the first applicable state: V_UP if tgt_v > vout; else F_SET if tgt_f != fout; else V_DN if tgt_v < vout; else DONE.
- V_UP:
  - At step entry, `vout` increments by 1 and the settle counter loads V_SETTLE-1.
  - Counter decrements each cycle. At 0: next step if vout != tgt_v; else F_SET (if tgt_f != fout) or DONE.
- F_SET:
  - At entry, `fout` = tgt_f in a single jump and the counter loads F_SETTLE-1.
  - At 0: V_DN if tgt_v < vout, else DONE.
- V_DN: mirror of V_UP, decrementing by 1. At 0 with vout == tgt_v, go to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `busy` = state != IDLE. `req_ready`=0 in every non-IDLE state.
- `emerg` is sampled only in IDLE. An emergency raised mid-sequence is serviced after DONE, provided it is still held.
- Levels are unsigned. Voltage moves only ±1 per step, so no wrap-around is possible.

## Timing
- The first output change occurs at edge E0+1.
- Each voltage step holds its value for exactly V_SETTLE cycles; the frequency change holds for F_SETTLE cycles.
- `done` is high during the cycle following edge E0 + 1 + Nv·V_SETTLE + Nf·F_SETTLE, where:
  - Nv = |tgt_v − vout at acceptance|;
  - Nf = 1 if tgt_f differs from `fout` at acceptance, else 0.
- Same-point request: `done` follows edge E0+1 and the outputs do not change.
- `req_ready` returns to 1 the cycle after `done`. Back-to-back acceptance is possible at that edge.
- `rst` during any state: at the next edge, all outputs take their reset values and any in-flight target is discarded.
- `vout` and `fout` never change in the same cycle.

## Structure
- Shared package `dpmu_pkg` holds:
  - the state enum (IDLE, V_UP, F_SET, V_DN, DONE);
  - level widths (V_W=2, F_W=3);
  - NORMAL reset operating-point constants.
- Sub-module `settle_timer`:
  - down-counter with `load`, `load_val`, `zero`;
  - width $clog2(max(V_SETTLE, F_SETTLE));
  - instantiated once and shared by all step states.

## Test plan
- Reset for 2 cycles → `vout`=01, `fout`=010, `req_ready`=1, `busy`=0, `done`=0.
- From reset, request (11, 111) accepted at E0 → `vout`=10 at E1, 11 at E9; `fout`=111 at E17; `done` after E21; `req_ready`=1 after E22.
- From (11, 111), request (00, 000) → `fout`=000 at E1; `vout`=10 at E5, 01 at E13, 00 at E21; `done` after E29.
- Request equal to the current point (01, 010) → no output change; `done` after E1. Then `req_valid` pulses while `busy` → ignored, `req_ready`=0, target unchanged.
- `emerg`=1 together with `req_valid`=1, request (11, 111), from (01, 010) → request not accepted; `fout`=000 at E1, `vout`=00 at E5; `done` after E13.
- Assert `rst` at E10 of the up sequence → at E11 `vout`=01, `fout`=010, IDLE, `busy`=0, and no `done` pulse.

Source files
------------

// File: rtl/dpmu_pkg.sv
// Shared definitions for the dynamic power management unit: level widths,
// the NORMAL operating point and the DVFS sequencer state encoding.
package dpmu_pkg;

   localparam int unsigned V_W = 2;
   localparam int unsigned F_W = 3;

   localparam logic [V_W-1:0] V_NORMAL = 2'b01;
   localparam logic [F_W-1:0] F_NORMAL = 3'b010;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      V_UP  = 3'd1,
      F_SET = 3'd2,
      V_DN  = 3'd3,
      DONE  = 3'd4
   } dvfs_state_e;

   // Picks the first state of a sequence: raise voltage before touching
   // frequency, and lower frequency before dropping voltage.
   function automatic dvfs_state_e first_state(input logic [V_W-1:0] tgt_v,
                                               input logic [V_W-1:0] cur_v,
                                               input logic [F_W-1:0] tgt_f,
                                               input logic [F_W-1:0] cur_f);
      dvfs_state_e st;
      if (tgt_v > cur_v) begin
         st = V_UP;
      end else if (tgt_f != cur_f) begin
         st = F_SET;
      end else if (tgt_v < cur_v) begin
         st = V_DN;
      end else begin
         st = DONE;
      end
      return st;
   endfunction

endpackage

// File: rtl/dvfs_sequencer_settle_timer.sv
// Shared settle down-counter: loads a hold length and counts to zero,
// where it rests until the next load.
module settle_timer #(
   parameter int unsigned W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] count_d;
   logic [W-1:0] count_q;

   // Next count: a load wins, otherwise decrement and saturate at zero.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (count_q != '0) begin
         count_d = count_q - W'(1);
      end
   end

   // Count register, cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/dvfs_sequencer.sv
// DVFS sequencer: applies a target (voltage, frequency) operating point in a
// safe order, stepping voltage one level at a time and holding each change
// for its settle time.
module dvfs_sequencer
   import dpmu_pkg::*;
#(
   parameter int unsigned    V_SETTLE = 8,
   parameter int unsigned    F_SETTLE = 4,
   parameter logic [V_W-1:0] V_RST    = V_NORMAL,
   parameter logic [F_W-1:0] F_RST    = F_NORMAL
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           req_valid,
   output logic           req_ready,
   input  logic [V_W-1:0] req_vlevel,
   input  logic [F_W-1:0] req_flevel,
   input  logic           emerg,
   output logic [V_W-1:0] vout,
   output logic [F_W-1:0] fout,
   output logic           busy,
   output logic           done
);

   localparam int unsigned MAX_SETTLE = (V_SETTLE > F_SETTLE) ? V_SETTLE : F_SETTLE;
   localparam int unsigned TW         = (MAX_SETTLE > 1) ? $clog2(MAX_SETTLE) : 1;
   localparam logic [TW-1:0] V_LOAD   = TW'(V_SETTLE - 1);
   localparam logic [TW-1:0] F_LOAD   = TW'(F_SETTLE - 1);

   dvfs_state_e    state_d, state_q;
   logic           first_d, first_q;
   logic [V_W-1:0] vout_d, vout_q;
   logic [F_W-1:0] fout_d, fout_q;
   logic [V_W-1:0] tgt_v_d, tgt_v_q;
   logic [F_W-1:0] tgt_f_d, tgt_f_q;

   logic           accept;
   logic           step;
   logic           tmr_load;
   logic [TW-1:0]  tmr_val;
   logic           tmr_zero;

   settle_timer #(
      .W (TW)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   // Next-state and datapath: first_q marks the cycle after acceptance so the
   // first change lands one edge later; afterwards a step state acts only
   // once the current hold has expired.
   always_comb begin
      state_d  = state_q;
      first_d  = first_q;
      vout_d   = vout_q;
      fout_d   = fout_q;
      tgt_v_d  = tgt_v_q;
      tgt_f_d  = tgt_f_q;
      accept   = 1'b0;
      tmr_load = 1'b0;
      tmr_val  = '0;
      step     = first_q || tmr_zero;

      case (state_q)
         IDLE: begin
            if (emerg) begin
               tgt_v_d = '0;
               tgt_f_d = '0;
               accept  = 1'b1;
            end else if (req_valid) begin
               tgt_v_d = req_vlevel;
               tgt_f_d = req_flevel;
               accept  = 1'b1;
            end
            if (accept) begin
               first_d = 1'b1;
               state_d = first_state(tgt_v_d, vout_q, tgt_f_d, fout_q);
            end
         end

         V_UP: begin
            if (step) begin
               first_d = 1'b0;
               if (vout_q != tgt_v_q) begin
                  vout_d   = vout_q + V_W'(1);
                  tmr_load = 1'b1;
                  tmr_val  = V_LOAD;
               end else if (fout_q != tgt_f_q) begin
                  state_d  = F_SET;
                  fout_d   = tgt_f_q;
                  tmr_load = 1'b1;
                  tmr_val  = F_LOAD;
               end else begin
                  state_d  = DONE;
               end
            end
         end

         F_SET: begin
            if (step) begin
               first_d = 1'b0;
               if (fout_q != tgt_f_q) begin
                  fout_d   = tgt_f_q;
                  tmr_load = 1'b1;
                  tmr_val  = F_LOAD;
               end else if (tgt_v_q < vout_q) begin
                  state_d  = V_DN;
                  vout_d   = vout_q - V_W'(1);
                  tmr_load = 1'b1;
                  tmr_val  = V_LOAD;
               end else begin
                  state_d  = DONE;
               end
            end
         end

         V_DN: begin
            if (step) begin
               first_d = 1'b0;
               if (vout_q != tgt_v_q) begin
                  vout_d   = vout_q - V_W'(1);
                  tmr_load = 1'b1;
                  tmr_val  = V_LOAD;
               end else begin
                  state_d  = DONE;
               end
            end
         end

         DONE: begin
            if (first_q) begin
               first_d = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
            first_d = 1'b0;
         end
      endcase
   end

   // State and operating-point registers; reset drops any in-flight target.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         first_q <= 1'b0;
         vout_q  <= V_RST;
         fout_q  <= F_RST;
         tgt_v_q <= V_RST;
         tgt_f_q <= F_RST;
      end else begin
         state_q <= state_d;
         first_q <= first_d;
         vout_q  <= vout_d;
         fout_q  <= fout_d;
         tgt_v_q <= tgt_v_d;
         tgt_f_q <= tgt_f_d;
      end
   end

   assign vout      = vout_q;
   assign fout      = fout_q;
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE) && !first_q;
   assign req_ready = (state_q == IDLE) && !emerg;

endmodule

// File: tb/tb_dvfs_sequencer.sv
// Self-checking bench for dvfs_sequencer: directed scenarios followed by
// random traffic, compared against a timeline model of each sequence.
module tb_dvfs_sequencer;

   localparam int VS    = 8;
   localparam int FS    = 4;
   localparam int V_RST = 1;
   localparam int F_RST = 2;

   logic       clk;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_vlevel;
   logic [2:0] req_flevel;
   logic       emerg;
   logic [1:0] vout;
   logic [2:0] fout;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;

   // Reference model: idle operating point, or an in-flight sequence
   // described by its start point, target and cycles since acceptance.
   int m_busy  = 0;
   int m_k     = 0;
   int m_cur_v = V_RST;
   int m_cur_f = F_RST;
   int m_v0, m_f0, m_tv, m_tf, m_nv, m_nf, m_up, m_t;

   dvfs_sequencer #(
      .V_SETTLE (VS),
      .F_SETTLE (FS),
      .V_RST    (2'b01),
      .F_RST    (3'b010)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_vlevel (req_vlevel),
      .req_flevel (req_flevel),
      .emerg      (emerg),
      .vout       (vout),
      .fout       (fout),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Advance the model by one clock edge given the inputs sampled there.
   task automatic modelEdge(input int r, input int v_i, input int e_i,
                            input int rv, input int rf);
      if (r != 0) begin
         m_busy  = 0;
         m_cur_v = V_RST;
         m_cur_f = F_RST;
      end else if (m_busy != 0) begin
         m_k++;
         if (m_k > m_t) begin
            m_busy  = 0;
            m_cur_v = m_tv;
            m_cur_f = m_tf;
         end
      end else if (e_i != 0 || v_i != 0) begin
         m_tv   = (e_i != 0) ? 0 : rv;
         m_tf   = (e_i != 0) ? 0 : rf;
         m_v0   = m_cur_v;
         m_f0   = m_cur_f;
         m_up   = (m_tv > m_v0) ? 1 : 0;
         m_nv   = m_up ? (m_tv - m_v0) : (m_v0 - m_tv);
         m_nf   = (m_tf != m_f0) ? 1 : 0;
         m_t    = 1 + m_nv * VS + m_nf * FS;
         m_k    = 0;
         m_busy = 1;
      end
   endtask

   // Compare DUT outputs with the model's view of the current cycle.
   task automatic checkCycle();
      int ev, ef, steps, base;
      if (m_busy == 0) begin
         checkOutput("vout", int'(vout), m_cur_v);
         checkOutput("fout", int'(fout), m_cur_f);
         checkOutput("busy", int'(busy), 0);
         checkOutput("done", int'(done), 0);
      end else begin
         if (m_up != 0) begin
            steps = (m_k >= 1) ? ((m_k - 1) / VS + 1) : 0;
            if (steps > m_nv) steps = m_nv;
            ev = m_v0 + steps;
            ef = (m_nf != 0 && m_k >= 1 + m_nv * VS) ? m_tf : m_f0;
         end else begin
            ef = (m_nf != 0 && m_k >= 1) ? m_tf : m_f0;
            base = 1 + m_nf * FS;
            steps = (m_nv > 0 && m_k >= base) ? ((m_k - base) / VS + 1) : 0;
            if (steps > m_nv) steps = m_nv;
            ev = m_v0 - steps;
         end
         checkOutput("vout", int'(vout), ev);
         checkOutput("fout", int'(fout), ef);
         checkOutput("busy", int'(busy), 1);
         checkOutput("done", int'(done), (m_k == m_t) ? 1 : 0);
      end
   endtask

   // Drive one cycle of inputs, check ready, clock, then check outputs.
   task automatic applyStimulus(input int r, input int v_i, input int e_i,
                                input int rv, input int rf);
      rst        = r[0];
      req_valid  = v_i[0];
      emerg      = e_i[0];
      req_vlevel = rv[1:0];
      req_flevel = rf[2:0];
      #1;
      checkOutput("req_ready", int'(req_ready), (m_busy == 0 && e_i == 0) ? 1 : 0);
      @(posedge clk);
      #1;
      modelEdge(r, v_i, e_i, rv, rf);
      checkCycle();
   endtask

   task automatic runUntilIdle(input int max_cycles);
      for (int i = 0; i < max_cycles && m_busy != 0; i++) begin
         applyStimulus(0, 0, 0, 0, 0);
      end
      checkOutput("idle_timeout", m_busy, 0);
      applyStimulus(0, 0, 0, 0, 0);
   endtask

   initial begin
      int r, v_i, e_i;
      rst        = 1'b1;
      req_valid  = 1'b0;
      emerg      = 1'b0;
      req_vlevel = '0;
      req_flevel = '0;

      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0);

      // Up sequence from reset, then the full way down.
      applyStimulus(0, 1, 0, 3, 7);
      runUntilIdle(60);
      applyStimulus(0, 1, 0, 0, 0);
      runUntilIdle(60);

      // Back to NORMAL, then a same-point request with a pulse while busy.
      applyStimulus(0, 1, 0, 1, 2);
      runUntilIdle(60);
      applyStimulus(0, 1, 0, 1, 2);
      applyStimulus(0, 1, 0, 3, 7);
      runUntilIdle(20);

      // Emergency overrides a simultaneous request.
      applyStimulus(0, 1, 1, 3, 7);
      runUntilIdle(60);

      // Reset in the middle of an up sequence.
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 3, 7);
      for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);

      // Random traffic including back-to-back requests, emergencies and resets.
      for (int i = 0; i < 3000; i++) begin
         r   = ($urandom_range(0, 299) == 0) ? 1 : 0;
         e_i = ($urandom_range(0, 11) == 0) ? 1 : 0;
         v_i = ($urandom_range(0, 2) == 0) ? 1 : 0;
         applyStimulus(r, v_i, e_i, $urandom_range(0, 3), $urandom_range(0, 7));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
